// File: rtl/pingpong_swap_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_swap_ctrl
//
// Purpose:
//   Coordinates a double-buffered (ping-pong) frame buffer with a VGA scan-out.
//   The writer fills the back buffer and pulses frame_done when it is complete.
//   The controller then holds off the writer until the start of vertical
//   blanking. At that point it swaps the buffers in a single cycle, so the
//   displayed image never tears and at most one swap happens per frame.
//
// Parameters:
//   H_VISIBLE     visible pixels per line
//   V_VISIBLE     visible lines per frame (the line on which vblank starts)
//
// Ports:
//   clk           single clock for all logic
//   reset_n       asynchronous, active-low reset
//   hc, vc        horizontal / vertical counters from the VGA timing generator
//   enable        when low, frame_done is ignored entirely
//   frame_done    one-cycle pulse from the writer: back buffer complete
//   write_to_two  buffer select for the writer (1 = writer targets buffer two)
//   wr_ready      writer may write the back buffer
//   swap_pulse    one-cycle pulse on every buffer swap
//   frame_count   number of swaps since reset (wraps at 2^16)
//   overrun_count number of dropped frame_done pulses (saturates at 255)
// ---------------------------------------------------------------------------
module pingpong_swap_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        enable,
  input  logic        frame_done,
  output logic        write_to_two,
  output logic        wr_ready,
  output logic        swap_pulse,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count
);

  localparam logic [1:0] ST_WRITE   = 2'd0;
  localparam logic [1:0] ST_WAIT_VB = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

  localparam logic [9:0] VB_LINE = 10'(V_VISIBLE);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       vb_start;
  logic       fd_valid;
  logic       fd_dropped;

  // vb_start marks the first pixel clock of the vblank line. Any other hc/vc
  // combination, including values outside the timing range, simply fails to
  // match. A degenerate zero-width line never produces a vblank start.
  assign vb_start   = (H_VISIBLE > 0) && (hc == 10'd0) && (vc == VB_LINE);
  assign fd_valid   = enable && frame_done;
  assign fd_dropped = fd_valid && ((state == ST_WAIT_VB) || (state == ST_SWAP));

  // Next-state logic for the swap handshake. A frame_done seen on a vb_start
  // cycle moves the FSM to WAIT_VB only after that vb_start has gone by, so
  // the swap naturally waits for the following vblank. SWAP always lasts
  // exactly one cycle. The unused encoding recovers to WRITE.
  always_comb begin
    next_state = state;
    case (state)
      ST_WRITE:   if (fd_valid) next_state = ST_WAIT_VB;
      ST_WAIT_VB: if (vb_start) next_state = ST_SWAP;
      ST_SWAP:    next_state = ST_WRITE;
      default:    next_state = ST_WRITE;
    endcase
  end

  // State and all outputs are registered. wr_ready and swap_pulse are decoded
  // from next_state so that they line up with the state they describe. The
  // buffer toggle and the frame count both happen on the edge leaving SWAP,
  // so a reset during WAIT_VB or SWAP discards the pending swap completely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_WRITE;
      write_to_two  <= 1'b0;
      wr_ready      <= 1'b1;
      swap_pulse    <= 1'b0;
      frame_count   <= 16'd0;
      overrun_count <= 8'd0;
    end else begin
      state      <= next_state;
      wr_ready   <= (next_state == ST_WRITE);
      swap_pulse <= (next_state == ST_SWAP);
      if (state == ST_SWAP) begin
        write_to_two <= ~write_to_two;
        frame_count  <= frame_count + 16'd1;
      end
      if (fd_dropped && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_swap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_swap_ctrl
//
// Purpose:
//   Directed, self-checking bench for pingpong_swap_ctrl. The hc/vc inputs
//   are driven straight to the values of interest instead of sweeping a full
//   800x525 raster. Each applyStimulus call spans exactly one clock cycle and
//   returns 1 time unit after the rising edge, where outputs are sampled.
// ---------------------------------------------------------------------------
module tb_pingpong_swap_ctrl;

  logic        clk;
  logic        reset_n;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        enable;
  logic        frame_done;
  logic        write_to_two;
  logic        wr_ready;
  logic        swap_pulse;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  int num_checks = 0;
  int num_errors = 0;

  pingpong_swap_ctrl #(
    .H_VISIBLE(640),
    .V_VISIBLE(480)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hc           (hc),
    .vc           (vc),
    .enable       (enable),
    .frame_done   (frame_done),
    .write_to_two (write_to_two),
    .wr_ready     (wr_ready),
    .swap_pulse   (swap_pulse),
    .frame_count  (frame_count),
    .overrun_count(overrun_count)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then return just after the rising edge
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic fd, input logic en);
    hc         = h;
    vc         = v;
    frame_done = fd;
    enable     = en;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against hand-computed expectations
  task automatic checkOutput(input string tag, input logic exp_w2,
                             input logic exp_rdy, input logic exp_swap,
                             input logic [15:0] exp_fc, input logic [7:0] exp_oc);
    num_checks++;
    assert (write_to_two === exp_w2) else begin
      num_errors++;
      $error("[TB] FAIL %s write_to_two got %0b expected %0b", tag, write_to_two, exp_w2);
    end
    num_checks++;
    assert (wr_ready === exp_rdy) else begin
      num_errors++;
      $error("[TB] FAIL %s wr_ready got %0b expected %0b", tag, wr_ready, exp_rdy);
    end
    num_checks++;
    assert (swap_pulse === exp_swap) else begin
      num_errors++;
      $error("[TB] FAIL %s swap_pulse got %0b expected %0b", tag, swap_pulse, exp_swap);
    end
    num_checks++;
    assert (frame_count === exp_fc) else begin
      num_errors++;
      $error("[TB] FAIL %s frame_count got %0d expected %0d", tag, frame_count, exp_fc);
    end
    num_checks++;
    assert (overrun_count === exp_oc) else begin
      num_errors++;
      $error("[TB] FAIL %s overrun_count got %0d expected %0d", tag, overrun_count, exp_oc);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    hc         = 10'd5;
    vc         = 10'd10;
    enable     = 1'b1;
    frame_done = 1'b0;

    // Reset values, both held in reset and after release
    applyStimulus(10'd5, 10'd10, 1'b0, 1'b1);
    applyStimulus(10'd5, 10'd10, 1'b0, 1'b1);
    checkOutput("reset_hold", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    reset_n = 1'b1;
    applyStimulus(10'd5, 10'd10, 1'b0, 1'b1);
    checkOutput("reset_release", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);

    // Basic swap: frame_done at vc=100, swap at vc=480/hc=0
    applyStimulus(10'd5, 10'd100, 1'b1, 1'b1);
    checkOutput("basic_wait", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd3, 10'd480, 1'b0, 1'b1);
    checkOutput("basic_hc_nonzero", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd0, 10'd479, 1'b0, 1'b1);
    checkOutput("basic_vc_wrong", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd0, 10'd1023, 1'b0, 1'b1);
    checkOutput("basic_vc_out_of_range", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    checkOutput("basic_swap", 1'b0, 1'b0, 1'b1, 16'd0, 8'd0);
    applyStimulus(10'd1, 10'd480, 1'b0, 1'b1);
    checkOutput("basic_after", 1'b1, 1'b1, 1'b0, 16'd1, 8'd0);

    // Coincident frame_done on the vb_start cycle waits a whole frame
    applyStimulus(10'd0, 10'd480, 1'b1, 1'b1);
    checkOutput("coinc_accept", 1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    applyStimulus(10'd1, 10'd480, 1'b0, 1'b1);
    applyStimulus(10'd5, 10'd10, 1'b0, 1'b1);
    applyStimulus(10'd5, 10'd300, 1'b0, 1'b1);
    checkOutput("coinc_no_swap", 1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    checkOutput("coinc_swap", 1'b1, 1'b0, 1'b1, 16'd1, 8'd0);
    applyStimulus(10'd1, 10'd480, 1'b0, 1'b1);
    checkOutput("coinc_after", 1'b0, 1'b1, 1'b0, 16'd2, 8'd0);

    // A vb_start in WRITE with no frame_done must not swap
    applyStimulus(10'd5, 10'd10, 1'b0, 1'b1);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    applyStimulus(10'd1, 10'd480, 1'b0, 1'b1);
    checkOutput("idle_vblank", 1'b0, 1'b1, 1'b0, 16'd2, 8'd0);

    // Overrun: second frame_done in the same frame is dropped
    applyStimulus(10'd5, 10'd100, 1'b1, 1'b1);
    applyStimulus(10'd5, 10'd150, 1'b0, 1'b1);
    applyStimulus(10'd5, 10'd200, 1'b1, 1'b1);
    checkOutput("overrun_drop", 1'b0, 1'b0, 1'b0, 16'd2, 8'd1);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    checkOutput("overrun_swap", 1'b0, 1'b0, 1'b1, 16'd2, 8'd1);
    applyStimulus(10'd5, 10'd1, 1'b0, 1'b1);
    checkOutput("overrun_after", 1'b1, 1'b1, 1'b0, 16'd3, 8'd1);

    // frame_done during the SWAP cycle is an overrun and does not re-arm
    applyStimulus(10'd5, 10'd100, 1'b1, 1'b1);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    applyStimulus(10'd5, 10'd2, 1'b1, 1'b1);
    checkOutput("swap_overrun", 1'b0, 1'b1, 1'b0, 16'd4, 8'd2);
    applyStimulus(10'd5, 10'd3, 1'b0, 1'b1);
    checkOutput("swap_overrun_idle", 1'b0, 1'b1, 1'b0, 16'd4, 8'd2);

    // Saturation: 300 extra pulses in WAIT_VB from a count of 2
    applyStimulus(10'd5, 10'd100, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(10'd5, 10'd200, 1'b1, 1'b1);
    end
    checkOutput("saturate", 1'b0, 1'b0, 1'b0, 16'd4, 8'd255);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    applyStimulus(10'd5, 10'd1, 1'b0, 1'b1);
    checkOutput("saturate_after", 1'b1, 1'b1, 1'b0, 16'd5, 8'd255);

    // Reset mid-WAIT_VB aborts the swap immediately (checked asynchronously)
    applyStimulus(10'd5, 10'd100, 1'b1, 1'b1);
    applyStimulus(10'd5, 10'd300, 1'b0, 1'b1);
    reset_n = 1'b0;
    #2;
    checkOutput("reset_async", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd5, 10'd300, 1'b0, 1'b1);
    reset_n = 1'b1;
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b1);
    checkOutput("reset_no_swap", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd1, 10'd480, 1'b0, 1'b1);
    checkOutput("reset_no_swap_after", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);

    // Enable gating: frame_done ignored across three frames
    for (int f = 0; f < 3; f++) begin
      applyStimulus(10'd5, 10'd100, 1'b1, 1'b0);
      applyStimulus(10'd5, 10'd200, 1'b1, 1'b0);
      applyStimulus(10'd0, 10'd480, 1'b1, 1'b0);
      applyStimulus(10'd5, 10'd10, 1'b0, 1'b0);
    end
    checkOutput("enable_gate", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);

    // Pending WAIT_VB still completes with enable low; no overrun counted
    applyStimulus(10'd5, 10'd100, 1'b1, 1'b1);
    applyStimulus(10'd5, 10'd200, 1'b1, 1'b0);
    checkOutput("enable_pending", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    applyStimulus(10'd0, 10'd480, 1'b0, 1'b0);
    checkOutput("enable_pending_swap", 1'b0, 1'b0, 1'b1, 16'd0, 8'd0);
    applyStimulus(10'd5, 10'd1, 1'b0, 1'b0);
    checkOutput("enable_pending_after", 1'b1, 1'b1, 1'b0, 16'd1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/pingpong_swap_ctrl.md
PINGPONG_SWAP_CTRL -- requirements
Module: pingpong_swap_ctrl

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter V_VISIBLE, default 480, meaning visible lines per frame; the vblank-start line.
REQ-003 The block SHALL have port clk  input  1  single clock for all logic.
REQ-004 The block SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port hc  input  10  horizontal counter from the VGA timing generator.
REQ-006 The block SHALL have port vc  input  10  vertical counter from the VGA timing generator.
REQ-007 The block SHALL have port enable  input  1  when 0, frame_done is ignored.
REQ-008 The block SHALL have port frame_done  input  1  one-cycle pulse from the writer: current back buffer complete.
REQ-009 The block SHALL have port write_to_two  output  1  drives ping_pong write_to_two; 1 = writer targets buffer two.
REQ-010 The block SHALL have port wr_ready  output  1  writer may write the back buffer.
REQ-011 The block SHALL have port swap_pulse  output  1  one-cycle pulse on every buffer swap.
REQ-012 The block SHALL have port frame_count  output  16  number of swaps since reset.
REQ-013 The block SHALL have port overrun_count  output  8  number of frame_done pulses dropped.

Function
REQ-014 The FSM SHALL have exactly three states: WRITE, WAIT_VB and SWAP; all outputs SHALL be registered.
REQ-015 vb_start SHALL be true on the single cycle with hc==0 and vc==V_VISIBLE.
REQ-016 In WRITE, wr_ready SHALL be 1; frame_done=1 with enable=1 SHALL move the FSM to WAIT_VB on the next edge.
REQ-017 A frame_done accepted on a vb_start cycle SHALL NOT swap in that vblank; it SHALL wait for the next vb_start.
REQ-018 In WAIT_VB, wr_ready SHALL be 0; vb_start SHALL move the FSM to SWAP on the next edge.
REQ-019 In SWAP (exactly one cycle), the block SHALL:
 - assert swap_pulse=1;
 - toggle write_to_two on the edge leaving SWAP;
 - increment frame_count modulo 2^16;
 - return to WRITE.
REQ-020 wr_ready SHALL be 0 in SWAP and 1 from the first WRITE cycle after SWAP; write_to_two SHALL change only on a SWAP exit edge.
REQ-021 frame_done=1 with enable=1 in WAIT_VB or SWAP SHALL increment overrun_count, saturating at 255, and SHALL NOT change state.
REQ-022 With enable=0:
 - frame_done SHALL cause no state change and no count change;
 - a pending WAIT_VB SHALL still complete its swap at vb_start.
REQ-023 Swap-to-swap latency SHALL be at least one full frame; at most one swap SHALL occur per frame.
REQ-024 hc/vc values outside the valid timing range SHALL only ever fail to match vb_start and SHALL cause no other effect.

Reset
REQ-025 While reset_n=0 the outputs SHALL be: state=WRITE, write_to_two=0, wr_ready=1, swap_pulse=0, frame_count=0, overrun_count=0.
REQ-026 Reset asserted mid-WAIT_VB or mid-SWAP SHALL abort the swap immediately: no toggle, no count increment.
REQ-027 Release of reset SHALL be synchronous-safe: the first active edge after deassertion SHALL see state WRITE.

Verification
REQ-028 Basic swap: frame_done at vc=100, then vc reaches 480/hc=0 -> next cycle swap_pulse=1; following cycle write_to_two=1, frame_count=1, wr_ready=1.
REQ-029 Coincident event: frame_done on the cycle hc=0/vc=480 -> no swap that frame; swap at the next vc=480, hc=0; frame_count=1.
REQ-030 Overrun: frame_done pulses at vc=100 and vc=200 of one frame -> overrun_count=1; one swap only.
REQ-031 Saturation: 300 extra frame_done pulses while in WAIT_VB -> overrun_count=255.
REQ-032 Enable gating: enable=0 with frame_done pulses across 3 frames -> write_to_two=0, frame_count=0, overrun_count=0.
REQ-033 Reset mid-operation: reset_n low in WAIT_VB at vc=300 -> all outputs at REQ-025 values; no swap at the next vc=480.
